random_delay: RTL and testbench

RANDOM_DELAY -- requirements
Module: random_delay

---
 rtl/random_delay_if.sv | 24 ++
 rtl/random_delay.sv | 80 ++++++++
 tb/tb_random_delay.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/random_delay_if.sv
// Handshake bundle between a random_delay block and its controller.
// The master side drives the requests and the LFSR value; the slave side is the delay block.
interface random_delay_if #(
    parameter int unsigned WIDTH = 7
);
    logic             en;
    logic             trigger;
    logic             cancel;
    logic [WIDTH-1:0] rnd;
    logic             lfsr_en;
    logic             busy;
    logic             time_out;
    logic [WIDTH-1:0] count;

    modport master (
        output en, trigger, cancel, rnd,
        input  lfsr_en, busy, time_out, count
    );

    modport slave (
        input  en, trigger, cancel, rnd,
        output lfsr_en, busy, time_out, count
    );
endinterface

// File: rtl/random_delay.sv
// Randomised one-shot delay: captures an LFSR value on trigger, counts it down on enabled
// edges and emits a single-cycle time_out pulse on expiry; cancel aborts silently.
module random_delay #(
    parameter int unsigned WIDTH = 7
) (
    input  logic           clk,
    input  logic           rst,
    random_delay_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_lfsr_en;
    logic             w_lfsr_en_nxt;
    logic             w_capture;

    assign w_capture = bus.trigger && !bus.cancel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_lfsr_en <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_lfsr_en <= w_lfsr_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_lfsr_en_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_count_nxt = '0;
                if (w_capture) begin
                    w_state_nxt   = COUNT;
                    // A zero draw still yields one enabled cycle of delay.
                    w_count_nxt   = (bus.rnd == '0) ? W_ONE : bus.rnd;
                    w_lfsr_en_nxt = 1'b1;
                end
            end
            COUNT: begin
                if (bus.cancel) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else if (bus.en && (r_count != '0)) begin
                    w_count_nxt = r_count - W_ONE;
                    if (r_count == W_ONE) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign bus.lfsr_en  = r_lfsr_en;
    assign bus.busy     = (r_state != IDLE);
    assign bus.time_out = (r_state == DONE);
    assign bus.count    = r_count;
endmodule

// File: tb/tb_random_delay.sv
// Directed bench for random_delay: an abstract delay model checked every cycle, plus
// hand-computed literal expectations for each scenario.
module tb_random_delay;
    localparam int unsigned WIDTH = 7;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    random_delay_if #(.WIDTH(WIDTH)) bus ();

    random_delay #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 = idle, 1 = waiting out m_left enabled edges, 2 = expiry cycle.
    int m_phase;
    int m_left;
    int m_req;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_left  <= 0;
            m_req   <= 0;
        end else begin
            m_req <= 0;
            if (m_phase == 0) begin
                m_left <= 0;
                if (bus.trigger && !bus.cancel) begin
                    m_phase <= 1;
                    m_left  <= (int'(bus.rnd) == 0) ? 1 : int'(bus.rnd);
                    m_req   <= 1;
                end
            end else if (m_phase == 1) begin
                if (bus.cancel) begin
                    m_phase <= 0;
                    m_left  <= 0;
                end else if (bus.en) begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
            end else begin
                m_phase <= 0;
                m_left  <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("cyc_busy",     int'(bus.busy),     (m_phase != 0) ? 1 : 0);
        chk("cyc_time_out", int'(bus.time_out), (m_phase == 2) ? 1 : 0);
        chk("cyc_count",    int'(bus.count),    m_left);
        chk("cyc_lfsr_en",  int'(bus.lfsr_en),  m_req);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input int busy, input int to, input int cnt, input int lf);
        chk({name, "_busy"},     int'(bus.busy),     busy);
        chk({name, "_time_out"}, int'(bus.time_out), to);
        chk({name, "_count"},    int'(bus.count),    cnt);
        chk({name, "_lfsr_en"},  int'(bus.lfsr_en),  lf);
    endtask

    initial begin
        int pulses;
        int reqs;
        int seen;
        int exp_gate [5];
        int en_gate  [5];

        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.trigger = 1'b0;
        bus.cancel  = 1'b0;
        bus.rnd     = '0;
        #2;
        chk_out("reset", 0, 0, 0, 0);
        #20;
        rst = 1'b1;
        step();
        chk_out("idle", 0, 0, 0, 0);

        // Basic delay, rnd=5
        bus.en = 1'b1; bus.rnd = 7'd5; bus.trigger = 1'b1;
        step();
        chk_out("basic_cap", 1, 0, 5, 1);
        bus.trigger = 1'b0; bus.rnd = 7'd99;
        for (int k = 4; k >= 1; k--) begin
            step();
            chk_out("basic_run", 1, 0, k, 0);
        end
        step();
        chk_out("basic_done", 1, 1, 0, 0);
        step();
        chk_out("basic_idle", 0, 0, 0, 0);

        // Gated enable, rnd=3, en 1,0,1,0,1
        en_gate  = '{1, 0, 1, 0, 1};
        exp_gate = '{2, 2, 1, 1, 0};
        bus.rnd = 7'd3; bus.trigger = 1'b1;
        step();
        chk("gate_cap_count", int'(bus.count), 3);
        bus.trigger = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.en = en_gate[i][0];
            step();
            chk("gate_count", int'(bus.count), exp_gate[i]);
            chk("gate_time_out", int'(bus.time_out), (i == 4) ? 1 : 0);
        end
        bus.en = 1'b1;
        step();

        // Zero draw
        bus.rnd = 7'd0; bus.trigger = 1'b1;
        step();
        chk_out("zero_cap", 1, 0, 1, 1);
        bus.trigger = 1'b0;
        step();
        chk_out("zero_done", 1, 1, 0, 0);
        step();

        // Max draw, latency measured from capture edge
        bus.rnd = 7'd127; bus.trigger = 1'b1;
        step();
        chk("max_cap_count", int'(bus.count), 127);
        bus.trigger = 1'b0;
        seen = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (bus.time_out) begin
                seen = i;
                break;
            end
        end
        chk("max_latency", seen, 127);
        step();
        chk("max_idle_busy", int'(bus.busy), 0);

        // Cancel on the expiry edge
        bus.rnd = 7'd2; bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        step();
        chk("race_count1", int'(bus.count), 1);
        bus.cancel = 1'b1;
        step();
        chk_out("race_cancel", 0, 0, 0, 0);
        bus.cancel = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(bus.time_out);
        end
        chk("race_no_pulse", pulses, 0);

        // Trigger and cancel together in IDLE
        bus.rnd = 7'd9; bus.trigger = 1'b1; bus.cancel = 1'b1;
        step();
        chk_out("trig_cancel", 0, 0, 0, 0);
        bus.trigger = 1'b0; bus.cancel = 1'b0;
        step();

        // Trigger held throughout: single expiry, recapture on first IDLE edge
        bus.rnd = 7'd4; bus.trigger = 1'b1;
        step();
        chk_out("held_cap", 1, 0, 4, 1);
        bus.rnd = 7'd6;
        pulses = 0;
        reqs   = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(bus.time_out);
            reqs   += int'(bus.lfsr_en);
        end
        chk("held_pulses", pulses, 1);
        chk("held_reqs", reqs, 0);
        chk("held_idle_busy", int'(bus.busy), 0);
        step();
        chk_out("held_recap", 1, 0, 6, 1);
        bus.trigger = 1'b0; bus.cancel = 1'b1;
        step();
        chk_out("held_cancel", 0, 0, 0, 0);
        bus.cancel = 1'b0;

        // Asynchronous reset mid-COUNT
        bus.rnd = 7'd10; bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            pulses += int'(bus.time_out) + int'(bus.busy);
        end
        chk("async_no_resume", pulses, 0);

        // Capture on the very first edge after release
        #3;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        bus.rnd = 7'd3; bus.trigger = 1'b1;
        step();
        chk_out("post_rst_cap", 1, 0, 3, 1);
        bus.trigger = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_idle", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
